// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops wide words from a synchronous FIFO and streams each one
// out as narrower valid/ready beats, least-significant slice first.
module fifo_rd_serializer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_rd,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last,
    output logic [CNT_WIDTH-1:0] word_cnt
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t                          state_q, state_d;
    logic [RATIO-1:0][OUT_WIDTH-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [CNT_WIDTH-1:0]            word_cnt_q, word_cnt_d;
    logic                            last_hs;

    always_comb begin
        last_hs    = (state_q == SEND) && m_ready && (idx_q == IDX_LAST);
        // A new fetch overlaps the final-beat handshake so only the LOAD cycle is a bubble.
        fifo_rd    = !reset && en && !fifo_empty && ((state_q == IDLE) || last_hs);
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd) state_d = LOAD;
            end
            LOAD: begin
                hold_d  = fifo_data;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (m_ready) begin
                    if (idx_q == IDX_LAST) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        state_d    = fifo_rd ? LOAD : IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign m_valid  = (state_q == SEND);
    assign m_last   = (state_q == SEND) && (idx_q == IDX_LAST);
    assign m_data   = hold_q[idx_q];
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: drives a queue-backed FIFO and checks every cycle
// against a beat-scoreboard model, plus directed literal checks.
module tb_fifo_rd_serializer;
    localparam int IW    = 128;
    localparam int OW    = 32;
    localparam int RATIO = IW / OW;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          fifo_empty;
    logic [IW-1:0] fifo_data;
    logic          m_ready;
    logic          fifo_rd, m_valid, m_last;
    logic [OW-1:0] m_data;
    logic [15:0]   word_cnt;
    logic          fifo_rd_s, m_valid_s, m_last_s;
    logic [OW-1:0] m_data_s;
    logic [2:0]    word_cnt_s;

    always #5 clk = ~clk;

    fifo_rd_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .word_cnt(word_cnt)
    );

    // Narrow counter copy on the same stimulus, so counter wrap is reachable quickly.
    fifo_rd_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(3)) dut_s (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd_s), .m_valid(m_valid_s), .m_ready(m_ready), .m_data(m_data_s),
        .m_last(m_last_s), .word_cnt(word_cnt_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [IW-1:0] fifo_q[$];
    logic [OW-1:0] exp_beats[$];
    int            beats_left = 0;
    bit            loading    = 0;
    bit            model_on   = 0;
    logic [15:0]   mcnt       = '0;
    bit            rd_seen    = 0;

    int            rd_log[$];
    logic [OW-1:0] beat_log[$];
    int            beat_cyc[$];
    bit            last_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        beat_log.delete();
        beat_cyc.delete();
        last_log.delete();
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Model: beats_left counts slices still owed for the displayed word; loading marks
    // the bubble cycle after a fetch.
    task automatic model_step();
        bit ev, el, hs, slot, er;
        logic [IW-1:0] w;
        ev   = (beats_left != 0);
        el   = (beats_left == 1);
        hs   = ev && m_ready;
        slot = (beats_left == 0 && !loading) || (hs && beats_left == 1);
        er   = !reset && en && !fifo_empty && slot;
        if (model_on) begin
            check("fifo_rd", fifo_rd, er);
            check("m_valid", m_valid, ev);
            check("m_last", m_last, el);
            check("word_cnt", word_cnt, mcnt);
            check("fifo_rd_small", fifo_rd_s, er);
            check("m_valid_small", m_valid_s, ev);
            check("m_last_small", m_last_s, el);
            check("word_cnt_small", word_cnt_s, mcnt[2:0]);
            if (ev) begin
                check("m_data", m_data, exp_beats[0]);
                check("m_data_small", m_data_s, exp_beats[0]);
            end
        end
        rd_seen = fifo_rd;
        if (fifo_rd) rd_log.push_back(cyc);
        if (m_valid && m_ready) begin
            beat_log.push_back(m_data);
            beat_cyc.push_back(cyc);
            last_log.push_back(m_last);
        end
        if (reset) begin
            beats_left = 0;
            loading    = 0;
            mcnt       = '0;
            exp_beats.delete();
            model_on   = 1;
        end else if (model_on) begin
            if (hs) begin
                void'(exp_beats.pop_front());
                beats_left--;
                if (beats_left == 0) mcnt++;
            end
            if (loading) begin
                beats_left = RATIO;
                loading    = 0;
            end
            if (er) begin
                w = fifo_q[0];
                for (int k = 0; k < RATIO; k++) exp_beats.push_back(w[k*OW +: OW]);
                loading = 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (rd_seen) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else fifo_data = 'x;
        end
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 8 && !m_valid; i++) cycle();
        check(name, m_valid, 1'b1);
    endtask

    logic [OW-1:0] bexp[4];
    logic [OW-1:0] dexp[4];
    bit            pat[7];

    initial begin
        reset = 1'b1; en = 1'b1; m_ready = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
        run(3);
        reset = 1'b0;
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_fifo_rd", fifo_rd, 1'b0);

        // Idle with an empty FIFO
        clear_logs();
        run(10);
        check("idle_rd_count", rd_log.size(), 0);
        check("idle_beat_count", beat_log.size(), 0);
        check("idle_word_cnt", word_cnt, 16'h0);

        // Single word
        clear_logs();
        bexp[0] = 32'hCCDDEEFF; bexp[1] = 32'h8899AABB; bexp[2] = 32'h44556677; bexp[3] = 32'h00112233;
        push_word(128'h00112233_44556677_8899AABB_CCDDEEFF);
        run(10);
        check("single_rd_count", rd_log.size(), 1);
        check("single_beat_count", beat_log.size(), 4);
        check("single_latency", beat_cyc[0] - rd_log[0], 2);
        check("single_span", beat_cyc[3] - beat_cyc[0], 3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("single_beat%0d", k), beat_log[k], bexp[k]);
            check($sformatf("single_last%0d", k), last_log[k], (k == 3));
        end
        check("single_word_cnt", word_cnt, 16'd1);

        // Three queued words back to back
        clear_logs();
        push_word(128'h11111111_22222222_33333333_44444444);
        push_word(128'h55555555_66666666_77777777_88888888);
        push_word(128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);
        run(20);
        check("three_rd_count", rd_log.size(), 3);
        check("three_beat_count", beat_log.size(), 12);
        check("three_span", beat_cyc[11] - beat_cyc[0] + 1, 14);
        check("three_rd1_on_last", rd_log[1], beat_cyc[3]);
        check("three_rd2_on_last", rd_log[2], beat_cyc[7]);
        check("three_word_cnt", word_cnt, 16'd4);

        // Backpressure pattern 1,0,0,1,0,1,1
        clear_logs();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        dexp[0] = 32'hFEEDFACE; dexp[1] = 32'h89ABCDEF; dexp[2] = 32'h01234567; dexp[3] = 32'hDEADBEEF;
        push_word(128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE);
        wait_valid("bp_wait_valid");
        for (int i = 0; i < 7; i++) begin
            m_ready = pat[i];
            cycle();
        end
        m_ready = 1'b1;
        run(4);
        check("bp_rd_count", rd_log.size(), 1);
        check("bp_beat_count", beat_log.size(), 4);
        check("bp_gap1", beat_cyc[1] - beat_cyc[0], 3);
        check("bp_gap2", beat_cyc[2] - beat_cyc[0], 5);
        check("bp_gap3", beat_cyc[3] - beat_cyc[0], 6);
        for (int k = 0; k < 4; k++) check($sformatf("bp_beat%0d", k), beat_log[k], dexp[k]);

        // Drop en after the first beat with more words waiting
        clear_logs();
        push_word(128'h0A0A0A0A_0B0B0B0B_0C0C0C0C_0D0D0D0D);
        push_word(128'h1A1A1A1A_1B1B1B1B_1C1C1C1C_1D1D1D1D);
        wait_valid("en_wait_valid");
        cycle();
        en = 1'b0;
        run(10);
        check("en_low_rd_count", rd_log.size(), 1);
        check("en_low_beat_count", beat_log.size(), 4);
        check("en_low_fifo_left", fifo_q.size(), 1);
        check("en_low_valid", m_valid, 1'b0);
        en = 1'b1;
        run(10);
        check("en_high_rd_count", rd_log.size(), 2);
        check("en_high_beat_count", beat_log.size(), 8);

        // Reset in the middle of a word
        reset = 1'b1; cycle(); reset = 1'b0;
        push_word(128'h76543210_FEDCBA98_13579BDF_2468ACE0);
        wait_valid("rst_mid_wait_valid");
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_mid_m_valid", m_valid, 1'b0);
        check("rst_mid_m_last", m_last, 1'b0);
        check("rst_mid_m_data", m_data, 32'h0);
        check("rst_mid_word_cnt", word_cnt, 16'h0);
        run(5);

        // Counter wrap on the 3-bit copy
        reset = 1'b1; cycle(); reset = 1'b0;
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 60 && word_cnt != 16'd7; i++) cycle();
        check("wrap_cnt7", word_cnt, 16'd7);
        check("wrap_small7", word_cnt_s, 3'd7);
        for (int i = 0; i < 10 && word_cnt != 16'd8; i++) cycle();
        check("wrap_cnt8", word_cnt, 16'd8);
        check("wrap_small0", word_cnt_s, 3'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom % 8) != 0;
            m_ready = ($urandom % 4) != 0;
            reset   = ($urandom % 200) == 0;
            if (($urandom % 3) == 0 && fifo_q.size() < 8)
                push_word({$urandom, $urandom, $urandom, $urandom});
            cycle();
        end
        reset = 1'b0;
        run(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
